// File: rtl/sram_banked_mport.sv
`default_nettype none
// ============================================================================
// Module   : sram_banked_mport
// Purpose  : Word-interleaved banked scratchpad shared by NUM_PORTS requesters.
//            Each port issues reads or byte-masked writes over valid/ready.
//            Requests to different banks proceed in parallel; requests that
//            collide on a bank are resolved by a per-bank round-robin pointer.
//            Every accepted request produces a response exactly one cycle
//            later (read data, or zero for writes).
// Ports    : clk_i        clock, all state on rising edge
//            rst_ni       asynchronous reset, active low
//            req_valid_i  per-port request valid
//            req_ready_o  per-port grant (accepted when valid & ready)
//            req_we_i     per-port write enable (1 = write, 0 = read)
//            req_addr_i   per-port word address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//            req_wdata_i  per-port write data
//            req_wmask_i  per-port byte enables
//            rsp_valid_o  per-port one-cycle response pulse
//            rsp_rdata_o  per-port read data (0 for write responses)
// Revision : 1.0 - initial release
// ============================================================================
module sram_banked_mport #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_WMASKS = DATA_WIDTH / 8,
  parameter bit IZERO      = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  input  logic [NUM_PORTS-1:0]             req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [NUM_PORTS*NUM_WMASKS-1:0]  req_wmask_i,
  output logic [NUM_PORTS-1:0]             rsp_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata_o
);

  localparam int c_BANK_W = $clog2(NUM_BANKS);
  localparam int c_ROW_W  = ADDR_WIDTH - c_BANK_W;
  localparam int c_ROWS   = (2 ** ADDR_WIDTH) / NUM_BANKS;
  localparam int c_PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Zero power-up content is supplied by the memory image that realises the
  // banks; the behavioural arrays below carry no power-up value of their own.
  logic w_izero_unused;
  assign w_izero_unused = IZERO;

  // Per-bank one-hot grant vectors, already gated by reset.
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  w_gnt;
  // Per-bank read data for the row addressed by that bank's winner.
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rd;
  logic [NUM_PORTS-1:0]                 w_ready;

  logic [NUM_PORTS-1:0]                 r_rsp_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rsp_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic [c_PORT_W-1:0]   w_idx;
    int                    w_pos;
    logic                  w_gnt_any;
    logic [c_ROW_W-1:0]    w_row;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NUM_WMASKS-1:0] w_wmask;
    logic [c_PORT_W-1:0]   r_rr;
    logic [DATA_WIDTH-1:0] r_mem [c_ROWS];

    // Ports whose address selects this bank (low address bits).
    always_comb begin
      w_req = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_req[p] = req_valid_i[p] &&
                   (req_addr_i[p*ADDR_WIDTH +: c_BANK_W] == c_BANK_W'(b));
      end
    end

    // First requester at or after the round-robin pointer, with wraparound.
    always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_pos   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_pos = (int'(r_rr) + k) % NUM_PORTS;
        if (!w_found && w_req[w_pos]) begin
          w_found = 1'b1;
          w_idx   = c_PORT_W'(w_pos);
        end
      end
    end

    assign w_gnt[b]  = (w_found && rst_ni) ? (NUM_PORTS'(1) << w_idx) : '0;
    assign w_gnt_any = |w_gnt[b];

    // Winner's request fields steer the single access this bank makes.
    assign w_row   = req_addr_i[int'(w_idx)*ADDR_WIDTH + c_BANK_W +: c_ROW_W];
    assign w_we    = req_we_i[w_idx];
    assign w_wdata = req_wdata_i[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_wmask = req_wmask_i[int'(w_idx)*NUM_WMASKS +: NUM_WMASKS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rr <= '0;
      end else if (w_gnt_any) begin
        r_rr <= (int'(w_idx) == NUM_PORTS - 1) ? '0 : w_idx + c_PORT_W'(1);
      end
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
      if (w_gnt_any && w_we) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          if (w_wmask[i]) begin
            r_mem[w_row][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end
    end

    // Pre-write contents: the response flop samples this at the write edge.
    assign w_bank_rd[b] = r_mem[w_row];
  end

  // A port can only be granted by the bank it addresses, so OR over banks.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_ready = w_ready | w_gnt[b];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rsp_valid[p] <= w_ready[p];
        if (w_ready[p]) begin
          r_rsp_rdata[p] <= req_we_i[p] ? '0 :
                            w_bank_rd[req_addr_i[p*ADDR_WIDTH +: c_BANK_W]];
        end
      end
    end
  end

  assign req_ready_o = w_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;

endmodule
`default_nettype wire
